// File: rtl/iter_divider_if.sv
// Purpose: handshake and operand/result bundle between the EX stage and the iterative divider.
// Latency: none; this file only groups wires.
// Backpressure: the requester holds start until ready pulses; there is no other flow control.
interface iter_divider_if;
  logic        start;
  logic        div_signed;
  logic [31:0] opr1;
  logic [31:0] opr2;
  logic        cancel;
  logic        ready;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        busy;

  // EX-stage side: issues requests, consumes results
  modport master (
    output start, div_signed, opr1, opr2, cancel,
    input  ready, quotient, remainder, busy
  );

  // Divider side
  modport slave (
    input  start, div_signed, opr1, opr2, cancel,
    output ready, quotient, remainder, busy
  );
endinterface

// File: rtl/iter_divider.sv
// Purpose: 32-bit radix-2 restoring divider for DIV/DIVU; signed operands are handled as magnitudes plus sign fixup.
// Latency: ready 33 cycles after start is accepted (1 cycle for zero/small-dividend cases when DIV_EARLY_OUT_EN is defined).
// Backpressure: start is a held level; dropping it or raising cancel while busy aborts with no ready and results unchanged.
module iter_divider (
  input  logic        clk,
  input  logic        resetn,
  iter_divider_if.slave div_if
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [32:0] prem;       // partial remainder
  logic [31:0] dividend;   // dividend bits shift out the top, quotient bits shift in the bottom
  logic [31:0] divisor;
  logic [4:0]  cnt;
  logic        qs;
  logic        rs;
  logic [31:0] quotient_q;
  logic [31:0] remainder_q;

  // Operand signs and magnitudes (signs forced to 0 for DIVU)
  logic        s1;
  logic        s2;
  logic [31:0] mag1;
  logic [31:0] mag2;
  logic        accept;
  logic        abort;
  logic        last_iter;

  // One restoring step
  logic [33:0] shifted;
  logic [33:0] diff;
  logic        step_ok;
  logic [32:0] prem_nxt;
  logic [31:0] quo_nxt;

  assign s1   = div_if.div_signed & div_if.opr1[31];
  assign s2   = div_if.div_signed & div_if.opr2[31];
  // Negating 0x80000000 yields 0x80000000, which read unsigned is the correct magnitude 2^31
  assign mag1 = s1 ? (~div_if.opr1 + 32'd1) : div_if.opr1;
  assign mag2 = s2 ? (~div_if.opr2 + 32'd1) : div_if.opr2;

  assign accept    = (state == ST_IDLE) & div_if.start & ~div_if.cancel;
  assign abort     = div_if.cancel | ~div_if.start;
  assign last_iter = (cnt == 5'd31);

  // Shift {prem, dividend} left by one and trial-subtract the divisor from the upper 33 bits
  always_comb begin
    shifted  = {prem, dividend[31]};
    diff     = shifted - {2'b00, divisor};
    step_ok  = ~diff[33];
    prem_nxt = step_ok ? diff[32:0] : shifted[32:0];
    quo_nxt  = {dividend[30:0], step_ok};
  end

`ifdef DIV_EARLY_OUT_EN
  // Cases whose result is known without iterating
  logic early_zero;
  logic early_small;
  assign early_zero  = (mag2 == 32'd0);
  assign early_small = (mag1 < mag2);
`endif

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; abort takes priority over completion in BUSY
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
`ifdef DIV_EARLY_OUT_EN
          state_nxt = (early_zero | early_small) ? ST_DONE : ST_BUSY;
`else
          state_nxt = ST_BUSY;
`endif
        end
      end
      ST_BUSY: begin
        if (abort)          state_nxt = ST_IDLE;
        else if (last_iter) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: operand capture, one quotient bit per BUSY cycle, signed result on the last step
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prem        <= 33'd0;
      dividend    <= 32'd0;
      divisor     <= 32'd0;
      cnt         <= 5'd0;
      qs          <= 1'b0;
      rs          <= 1'b0;
      quotient_q  <= 32'd0;
      remainder_q <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            dividend <= mag1;
            divisor  <= mag2;
            qs       <= s1 ^ s2;
            rs       <= s1;
            prem     <= 33'd0;
            cnt      <= 5'd0;
`ifdef DIV_EARLY_OUT_EN
            // Re-signing |opr1| with its own sign gives back opr1 in both shortcut cases
            if (early_zero) begin
              quotient_q  <= (s1 ^ s2) ? 32'd1 : 32'hFFFF_FFFF;
              remainder_q <= div_if.opr1;
            end else if (early_small) begin
              quotient_q  <= 32'd0;
              remainder_q <= div_if.opr1;
            end
`endif
          end
        end
        ST_BUSY: begin
          if (!abort) begin
            prem     <= prem_nxt;
            dividend <= quo_nxt;
            cnt      <= cnt + 5'd1;
            if (last_iter) begin
              quotient_q  <= qs ? (~quo_nxt + 32'd1) : quo_nxt;
              remainder_q <= rs ? (~prem_nxt[31:0] + 32'd1) : prem_nxt[31:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign div_if.ready     = (state == ST_DONE);
  assign div_if.busy      = (state == ST_BUSY);
  assign div_if.quotient  = quotient_q;
  assign div_if.remainder = remainder_q;

endmodule

// File: tb/tb_iter_divider.sv
// Directed bench for iter_divider: results, latency, busy length, cancel, async reset and back-to-back issue.
module tb_iter_divider;

`ifdef DIV_EARLY_OUT_EN
  localparam int EARLY_LAT  = 1;
  localparam int EARLY_BUSY = 0;
`else
  localparam int EARLY_LAT  = 33;
  localparam int EARLY_BUSY = 32;
`endif

  logic clk;
  logic resetn;
  int   n_checks;
  int   n_fail;
  int   lat;
  int   bcnt;
  int   seen;

  iter_divider_if dif ();

  iter_divider dut (
    .clk    (clk),
    .resetn (resetn),
    .div_if (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one division and hold start until ready (bounded); returns edges from acceptance to ready
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output int l, output int bc);
    @(negedge clk);
    dif.div_signed = sgn;
    dif.opr1       = a;
    dif.opr2       = b;
    dif.start      = 1'b1;
    l  = 0;
    bc = 0;
    while (l < 100) begin
      @(posedge clk);
      #1;
      l++;
      if (dif.busy) bc++;
      if (dif.ready) break;
    end
    dif.start = 1'b0;
  endtask

  // Full division check: latency, busy length, results, and one-cycle ready pulse
  task automatic check_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                           input int elat, input int ebusy);
    int l;
    int bc;
    run_div(sgn, a, b, l, bc);
    chk({tag, "_lat"}, l, elat);
    chk({tag, "_busy"}, bc, ebusy);
    chk({tag, "_q"}, dif.quotient, eq);
    chk({tag, "_r"}, dif.remainder, er);
    @(posedge clk);
    #1;
    chk({tag, "_ready_drop"}, {31'b0, dif.ready}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    resetn         = 1'b0;
    dif.start      = 1'b0;
    dif.div_signed = 1'b0;
    dif.opr1       = 32'd0;
    dif.opr2       = 32'd0;
    dif.cancel     = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, dif.ready}, 32'd0);
    chk("rst_busy", {31'b0, dif.busy}, 32'd0);
    chk("rst_q", dif.quotient, 32'd0);
    chk("rst_r", dif.remainder, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Main function
    check_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, 32);
    check_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, 32);
    check_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001, 33, 32);
    check_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33, 32);
    check_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 33, 32);
    check_div("divu_5_0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, EARLY_LAT, EARLY_BUSY);
    // Signed divide by zero: magnitude q all ones negated -> 1, r = -5
    check_div("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'd1, 32'hFFFF_FFFB, EARLY_LAT, EARLY_BUSY);
    check_div("divu_5_9", 1'b0, 32'd5, 32'd9, 32'd0, 32'd5, EARLY_LAT, EARLY_BUSY);

    // Cancel at iteration 10: no ready, results keep 0 / 5
    @(negedge clk);
    dif.div_signed = 1'b0;
    dif.opr1       = 32'd100;
    dif.opr2       = 32'd7;
    dif.start      = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    chk("cancel_busy_before", {31'b0, dif.busy}, 32'd1);
    dif.cancel = 1'b1;
    @(posedge clk);
    #1;
    chk("cancel_busy_after", {31'b0, dif.busy}, 32'd0);
    dif.cancel = 1'b0;
    dif.start  = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (dif.ready) seen++;
    end
    chk("cancel_no_ready", seen, 0);
    chk("cancel_q_kept", dif.quotient, 32'd0);
    chk("cancel_r_kept", dif.remainder, 32'd5);

    // Async reset at iteration 20 clears outputs without waiting for a clock edge
    @(negedge clk);
    dif.div_signed = 1'b1;
    dif.opr1       = 32'hFFFF_FFF9;
    dif.opr2       = 32'd2;
    dif.start      = 1'b1;
    @(posedge clk);
    repeat (20) @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    chk("arst_q", dif.quotient, 32'd0);
    chk("arst_r", dif.remainder, 32'd0);
    chk("arst_busy", {31'b0, dif.busy}, 32'd0);
    chk("arst_ready", {31'b0, dif.ready}, 32'd0);
    dif.start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    check_div("restart_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, 32);

    // Back-to-back: start reasserted right after the first ready
    run_div(1'b1, 32'hFFFF_FF9C, 32'd7, lat, bcnt);
    chk("b2b_first_lat", lat, 33);
    chk("b2b_first_q", dif.quotient, 32'hFFFF_FFF2);
    chk("b2b_first_r", dif.remainder, 32'hFFFF_FFFE);
    dif.div_signed = 1'b0;
    dif.opr1       = 32'd100;
    dif.opr2       = 32'd7;
    dif.start      = 1'b1;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (dif.ready) break;
    end
    dif.start = 1'b0;
    chk("b2b_spacing", lat, 34);
    chk("b2b_second_q", dif.quotient, 32'd14);
    chk("b2b_second_r", dif.remainder, 32'd2);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
